// File: rtl/triplet_packer.sv
// rtl/triplet_packer.sv - packs a byte stream into padded (a, b, c) triplets for the minimum stage
// and tracks the stage's fixed latency so the consumer knows when d is valid.
module triplet_packer #(
  parameter int W     = 8,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     c,
  output logic             abc_valid,
  output logic             res_valid,
  output logic [CNT_W-1:0] trip_cnt
);

  typedef enum logic [1:0] {
    S_A = 2'd0,
    S_B = 2'd1,
    S_C = 2'd2
  } state_t;

  // All-ones can never win a minimum, so it is a neutral pad.
  localparam logic [W-1:0]     PAD     = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic           accept;
  logic           emit;
  logic [W-1:0]   ea;
  logic [W-1:0]   eb;
  logic [W-1:0]   ec;
  logic [LAT-1:0] res_pipe;

  assign accept    = in_valid && in_ready;
  assign res_valid = res_pipe[LAT-1];

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    ea        = in_data;
    eb        = PAD;
    ec        = PAD;
    if (accept) begin
      case (state)
        S_A: begin
          if (in_last) begin
            emit      = 1'b1;
            state_nxt = S_A;
          end else begin
            state_nxt = S_B;
          end
        end
        S_B: begin
          ea = sa;
          eb = in_data;
          if (in_last) begin
            emit      = 1'b1;
            state_nxt = S_A;
          end else begin
            state_nxt = S_C;
          end
        end
        S_C: begin
          ea        = sa;
          eb        = sb;
          ec        = in_data;
          emit      = 1'b1;
          state_nxt = S_A;
        end
        default: state_nxt = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      sa        <= '0;
      sb        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      abc_valid <= 1'b0;
      trip_cnt  <= '0;
      in_ready  <= 1'b0;
      res_pipe  <= '0;
    end else begin
      // No backpressure downstream, so ready stays up once out of reset.
      in_ready  <= 1'b1;
      state     <= state_nxt;
      abc_valid <= emit;
      if (accept && state == S_A) sa <= in_data;
      if (accept && state == S_B) sb <= in_data;
      if (emit) begin
        a        <= ea;
        b        <= eb;
        c        <= ec;
        trip_cnt <= trip_cnt + CNT_ONE;
      end
      res_pipe[0] <= abc_valid;
      for (int i = 1; i < LAT; i++) res_pipe[i] <= res_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_triplet_packer.sv
// tb/tb_triplet_packer.sv - randomized self-checking bench for triplet_packer with a grouping
// model and a behavioural model of the downstream minimum stage.
module tb_triplet_packer;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  a, b, c;
  logic        abc_valid, res_valid;
  logic [15:0] trip_cnt;

  triplet_packer #(.W(8), .LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .abc_valid(abc_valid),
    .res_valid(res_valid), .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] c; } trip_t;
  typedef struct { int cyc; logic [7:0] m; } res_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  trip_t       exp_q[$];
  res_t        res_q[$];
  logic [7:0]  cur[$];
  int          abc_log[$];
  int          res_log[$];
  logic [15:0] seen_cnt = '0;
  logic [7:0]  d_pipe[LAT];
  logic [7:0]  d;

  function automatic logic [7:0] min3(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    logic [7:0] m;
    m = x;
    if (y < m) m = y;
    if (z < m) m = z;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Downstream minimum stage: LAT registers recomputing on whatever a/b/c hold.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    d_pipe[0] <= min3(a, b, c);
    for (int i = 1; i < LAT; i++) d_pipe[i] <= d_pipe[i-1];
  end
  assign d = d_pipe[LAT-1];

  // Grouping rule: a group closes after three bytes or on a byte flagged last.
  function automatic void model_byte(input logic [7:0] v, input logic l);
    trip_t t;
    cur.push_back(v);
    if (cur.size() == 3 || l) begin
      t.a = cur[0];
      t.b = (cur.size() > 1) ? cur[1] : 8'hFF;
      t.c = (cur.size() > 2) ? cur[2] : 8'hFF;
      exp_q.push_back(t);
      cur.delete();
    end
  endfunction

  always @(negedge clk) begin
    trip_t t;
    res_t  r;
    if (abc_valid === 1'b1) begin
      check("abc_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        check("a", a, t.a);
        check("b", b, t.b);
        check("c", c, t.c);
        seen_cnt = seen_cnt + 16'd1;
        check("trip_cnt_at_emit", trip_cnt, seen_cnt);
        r.cyc = cyc + LAT;
        r.m   = min3(t.a, t.b, t.c);
        res_q.push_back(r);
        abc_log.push_back(cyc);
      end
    end
    if (res_valid === 1'b1) begin
      check("res_expected", res_q.size() > 0, 1);
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        check("res_cycle", cyc, r.cyc);
        check("d", d, r.m);
        res_log.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_last = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic l);
    in_data  = v;
    in_last  = l;
    in_valid = 1'b1;
    check("in_ready_at_send", in_ready, 1);
    if (in_ready === 1'b1) model_byte(v, l);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    idle(LAT + 4);
    check("exp_q_empty", exp_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    res_q.delete();
    cur.delete();
    seen_cnt = '0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_abc", {a, b, c}, 0);
    check("rst_abc_valid", abc_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_trip_cnt", trip_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);
    abc_log.delete();
    res_log.delete();
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Full triplet 30/10/20.
    send_byte(8'h30, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    drain();
    check("t1_trip_cnt", trip_cnt, 1);
    check("t1_abc_pulses", abc_log.size(), 1);

    // Padded short groups.
    do_reset();
    send_byte(8'h05, 1'b1);
    send_byte(8'h07, 1'b0);
    send_byte(8'h02, 1'b1);
    drain();
    check("t2_trip_cnt", trip_cnt, 2);
    check("t2_res_pulses", res_log.size(), 2);

    // Twelve random bytes with bubbles.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 2));
      send_byte(8'($urandom), 1'b0);
    end
    drain();
    check("t3_abc_pulses", abc_log.size(), 4);
    check("t3_res_pulses", res_log.size(), 4);
    for (int i = 0; i < 4 && i < abc_log.size() && i < res_log.size(); i++)
      check("t3_res_lag", res_log[i] - abc_log[i], LAT);

    // Reset right after byte b is accepted; the partial group must vanish.
    do_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    drain();
    check("t4_trip_cnt", trip_cnt, 1);
    check("t4_abc_pulses", abc_log.size(), 1);
    check("t4_res_pulses", res_log.size(), 1);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 65535; i++) send_byte(8'($urandom), 1'b1);
    drain();
    check("t5_trip_cnt_max", trip_cnt, 16'hFFFF);
    send_byte(8'h11, 1'b1);
    drain();
    check("t5_trip_cnt_wrap", trip_cnt, 0);

    // Back-to-back single-byte groups.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    drain();
    check("t6_abc_pulses", abc_log.size(), 5);
    check("t6_res_pulses", res_log.size(), 5);
    for (int i = 0; i < 5 && i < abc_log.size() && i < res_log.size(); i++) begin
      check("t6_abc_consec", abc_log[i] - abc_log[0], i);
      check("t6_res_lag", res_log[i] - abc_log[i], LAT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
